// File: rtl/multicycle_control_unit.sv
// Purpose : Moore FSM sequencing the multicycle MIPS datapath (lw, sw, R-type, addi, beq[/bne]).
// Latency : one instruction step per clk; lw 5, sw/R-type/addi 4, beq/bne 3 cycles from FETCH.
// Backpressure: none; the datapath never stalls the sequencer. ILLEGAL is sticky until reset.
//
// Optional feature: define BNE_EN to decode opcode 0x05 (bne) into BRANCH with an
// inverted-zero PC enable. Without it, 0x05 is an illegal opcode.
//
// Ports:
//   clk, reset           rising-edge clock, synchronous active-low reset
//   opcode_i, funct_i    instruction register fields [31:26] and [5:0]
//   alu_zero_i           ALU zero flag, used combinationally in BRANCH
//   enable_*             PC / memory write / IR / register-file write enables
//   Selector_*           datapath multiplexer and ALU operation selects
//   state_o, illegal_o   debug view of the current state and the trap flag

module multicycle_control_unit (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] opcode_i,
   input  logic [5:0] funct_i,
   input  logic       alu_zero_i,
   output logic       enable_PC,
   output logic       Selector_Addr,
   output logic       enable_MemSys,
   output logic       enable_RegIns,
   output logic       enable_RF,
   output logic       Selector_RF_WR,
   output logic       Selector_RF_WD,
   output logic       Selector_ALU_Src_A,
   output logic [1:0] Selector_ALU_Src_B,
   output logic [2:0] Selector_ALU_Op,
   output logic       Selector_PC_Source,
   output logic [3:0] state_o,
   output logic       illegal_o
);

   // ------------------------------------------------------------------
   // State encodings
   // ------------------------------------------------------------------
   localparam logic [3:0] FETCH     = 4'd0;
   localparam logic [3:0] DECODE    = 4'd1;
   localparam logic [3:0] MEM_ADDR  = 4'd2;
   localparam logic [3:0] MEM_READ  = 4'd3;
   localparam logic [3:0] MEM_WB    = 4'd4;
   localparam logic [3:0] MEM_WRITE = 4'd5;
   localparam logic [3:0] EXECUTE   = 4'd6;
   localparam logic [3:0] ALU_WB    = 4'd7;
   localparam logic [3:0] ADDI_EXEC = 4'd8;
   localparam logic [3:0] ADDI_WB   = 4'd9;
   localparam logic [3:0] BRANCH    = 4'd10;
   localparam logic [3:0] ILLEGAL   = 4'd15;

   // ------------------------------------------------------------------
   // Instruction fields
   // ------------------------------------------------------------------
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_ADD   = 6'h20;
   localparam logic [5:0] FN_SUB   = 6'h22;
   localparam logic [5:0] FN_AND   = 6'h24;
   localparam logic [5:0] FN_OR    = 6'h25;
   localparam logic [5:0] FN_SLT   = 6'h2A;

   // ALU operation codes
   localparam logic [2:0] ALU_AND  = 3'b000;
   localparam logic [2:0] ALU_OR   = 3'b001;
   localparam logic [2:0] ALU_ADD  = 3'b010;
   localparam logic [2:0] ALU_SUB  = 3'b110;
   localparam logic [2:0] ALU_SLT  = 3'b111;

   // ALU source B selections
   localparam logic [1:0] SRCB_REG  = 2'b00;
   localparam logic [1:0] SRCB_FOUR = 2'b01;
   localparam logic [1:0] SRCB_IMM  = 2'b10;
   localparam logic [1:0] SRCB_BOFF = 2'b11;

   logic [3:0] state;
   logic [3:0] next_state;
   logic [3:0] out_state;     // state used for output decode (FETCH while in reset)

   logic       funct_ok;
   logic [2:0] funct_alu_op;
   logic       is_bne;
   logic       branch_take;

   // Raw enables before the reset gate
   logic       pc_en_raw;
   logic       mem_en_raw;
   logic       ir_en_raw;
   logic       rf_en_raw;

   // ------------------------------------------------------------------
   // R-type funct decode
   // ------------------------------------------------------------------
   always_comb begin
      funct_ok     = 1'b1;
      funct_alu_op = ALU_AND;
      case (funct_i)
         FN_ADD:  funct_alu_op = ALU_ADD;
         FN_SUB:  funct_alu_op = ALU_SUB;
         FN_AND:  funct_alu_op = ALU_AND;
         FN_OR:   funct_alu_op = ALU_OR;
         FN_SLT:  funct_alu_op = ALU_SLT;
         default: funct_ok     = 1'b0;
      endcase
   end

   // ------------------------------------------------------------------
   // Branch sense: bne only exists when the feature is built in, so the
   // default build reduces BRANCH to a plain beq.
   // ------------------------------------------------------------------
`ifdef BNE_EN
   assign is_bne = (opcode_i == OP_BNE);
`else
   assign is_bne = 1'b0;
`endif

   assign branch_take = is_bne ? ~alu_zero_i : alu_zero_i;

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      next_state = ILLEGAL;
      case (state)
         FETCH: next_state = DECODE;

         DECODE: begin
            case (opcode_i)
               OP_LW,
               OP_SW:    next_state = MEM_ADDR;
               OP_RTYPE: next_state = EXECUTE;
               OP_ADDI:  next_state = ADDI_EXEC;
               OP_BEQ:   next_state = BRANCH;
`ifdef BNE_EN
               OP_BNE:   next_state = BRANCH;
`endif
               default:  next_state = ILLEGAL;
            endcase
         end

         // Only lw and sw reach MEM_ADDR, so anything not sw is a load.
         MEM_ADDR:  next_state = (opcode_i == OP_SW) ? MEM_WRITE : MEM_READ;
         MEM_READ:  next_state = MEM_WB;
         MEM_WB:    next_state = FETCH;
         MEM_WRITE: next_state = FETCH;

         // An unknown funct traps here, before ALU_WB could write the RF.
         EXECUTE:   next_state = funct_ok ? ALU_WB : ILLEGAL;
         ALU_WB:    next_state = FETCH;

         ADDI_EXEC: next_state = ADDI_WB;
         ADDI_WB:   next_state = FETCH;

         BRANCH:    next_state = FETCH;

         // ILLEGAL is sticky; unused encodings 11-14 fall in here too.
         default:   next_state = ILLEGAL;
      endcase
   end

   // ------------------------------------------------------------------
   // State register, synchronous active-low reset
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= FETCH;
      end else begin
         state <= next_state;
      end
   end

   // While reset is held the outputs present the FETCH selectors so the
   // datapath sees a stable, harmless configuration; enables are gated below.
   assign out_state = reset ? state : FETCH;

   // ------------------------------------------------------------------
   // Output decode (Moore, except PC enable in BRANCH and ALU op in EXECUTE)
   // ------------------------------------------------------------------
   always_comb begin
      pc_en_raw          = 1'b0;
      mem_en_raw         = 1'b0;
      ir_en_raw          = 1'b0;
      rf_en_raw          = 1'b0;
      Selector_Addr      = 1'b0;
      Selector_RF_WR     = 1'b0;
      Selector_RF_WD     = 1'b0;
      Selector_ALU_Src_A = 1'b0;
      Selector_ALU_Src_B = SRCB_REG;
      Selector_ALU_Op    = ALU_AND;
      Selector_PC_Source = 1'b0;
      illegal_o          = 1'b0;

      case (out_state)
         FETCH: begin
            // IR <- mem[PC]; PC <- PC + 4
            Selector_Addr      = 1'b0;
            ir_en_raw          = 1'b1;
            Selector_ALU_Src_A = 1'b0;
            Selector_ALU_Src_B = SRCB_FOUR;
            Selector_ALU_Op    = ALU_ADD;
            Selector_PC_Source = 1'b0;
            pc_en_raw          = 1'b1;
         end

         DECODE: begin
            // Speculatively compute the branch target into ALU-out.
            Selector_ALU_Src_A = 1'b0;
            Selector_ALU_Src_B = SRCB_BOFF;
            Selector_ALU_Op    = ALU_ADD;
         end

         MEM_ADDR, ADDI_EXEC: begin
            // A + sign-extended immediate
            Selector_ALU_Src_A = 1'b1;
            Selector_ALU_Src_B = SRCB_IMM;
            Selector_ALU_Op    = ALU_ADD;
         end

         MEM_READ: begin
            Selector_Addr = 1'b1;
         end

         MEM_WB: begin
            rf_en_raw      = 1'b1;
            Selector_RF_WR = 1'b0;
            Selector_RF_WD = 1'b1;
         end

         MEM_WRITE: begin
            Selector_Addr = 1'b1;
            mem_en_raw    = 1'b1;
         end

         EXECUTE: begin
            Selector_ALU_Src_A = 1'b1;
            Selector_ALU_Src_B = SRCB_REG;
            Selector_ALU_Op    = funct_alu_op;
         end

         ALU_WB: begin
            rf_en_raw      = 1'b1;
            Selector_RF_WR = 1'b1;
            Selector_RF_WD = 1'b0;
         end

         ADDI_WB: begin
            rf_en_raw      = 1'b1;
            Selector_RF_WR = 1'b0;
            Selector_RF_WD = 1'b0;
         end

         BRANCH: begin
            // Compare A - B now; load PC with ALU-out (target) on the outcome.
            Selector_ALU_Src_A = 1'b1;
            Selector_ALU_Src_B = SRCB_REG;
            Selector_ALU_Op    = ALU_SUB;
            Selector_PC_Source = 1'b1;
            pc_en_raw          = branch_take;
         end

         ILLEGAL: begin
            illegal_o = 1'b1;
         end

         default: begin
            // Encodings 11-14: everything idle for the single cycle before ILLEGAL.
         end
      endcase
   end

   // Write enables are forced low combinationally during reset so an
   // abandoned instruction cannot commit anything in the reset cycle.
   assign enable_PC     = pc_en_raw  & reset;
   assign enable_MemSys = mem_en_raw & reset;
   assign enable_RegIns = ir_en_raw  & reset;
   assign enable_RF     = rf_en_raw  & reset;

   assign state_o = out_state;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Purpose : self-checking bench for multicycle_control_unit using a table of per-step expectations.
// Latency : samples outputs 1 ns after each rising edge; one table step per clock.
// Backpressure: n/a; directed stimulus only, all waits are fixed cycle counts.

module tb_multicycle_control_unit;

   logic       clk;
   logic       reset;
   logic [5:0] opcode_i;
   logic [5:0] funct_i;
   logic       alu_zero_i;
   logic       enable_PC;
   logic       Selector_Addr;
   logic       enable_MemSys;
   logic       enable_RegIns;
   logic       enable_RF;
   logic       Selector_RF_WR;
   logic       Selector_RF_WD;
   logic       Selector_ALU_Src_A;
   logic [1:0] Selector_ALU_Src_B;
   logic [2:0] Selector_ALU_Op;
   logic       Selector_PC_Source;
   logic [3:0] state_o;
   logic       illegal_o;

   multicycle_control_unit dut (
      .clk                (clk),
      .reset              (reset),
      .opcode_i           (opcode_i),
      .funct_i            (funct_i),
      .alu_zero_i         (alu_zero_i),
      .enable_PC          (enable_PC),
      .Selector_Addr      (Selector_Addr),
      .enable_MemSys      (enable_MemSys),
      .enable_RegIns      (enable_RegIns),
      .enable_RF          (enable_RF),
      .Selector_RF_WR     (Selector_RF_WR),
      .Selector_RF_WD     (Selector_RF_WD),
      .Selector_ALU_Src_A (Selector_ALU_Src_A),
      .Selector_ALU_Src_B (Selector_ALU_Src_B),
      .Selector_ALU_Op    (Selector_ALU_Op),
      .Selector_PC_Source (Selector_PC_Source),
      .state_o            (state_o),
      .illegal_o          (illegal_o)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Control word: {en_pc, sel_addr, en_mem, en_ir, en_rf, rf_wr, rf_wd,
   //                src_a, src_b[1:0], alu_op[2:0], pc_src, illegal}
   logic [14:0] ctl;
   assign ctl = {enable_PC, Selector_Addr, enable_MemSys, enable_RegIns, enable_RF,
                 Selector_RF_WR, Selector_RF_WD, Selector_ALU_Src_A, Selector_ALU_Src_B,
                 Selector_ALU_Op, Selector_PC_Source, illegal_o};

   localparam logic [3:0] S_FE = 4'd0,  S_DE = 4'd1,  S_MA = 4'd2,  S_MR = 4'd3;
   localparam logic [3:0] S_MW = 4'd4,  S_SW = 4'd5,  S_EX = 4'd6,  S_AW = 4'd7;
   localparam logic [3:0] S_IE = 4'd8,  S_IW = 4'd9,  S_BR = 4'd10, S_IL = 4'd15;

   localparam logic [14:0] C_FETCH = {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 3'b010, 1'b0, 1'b0};
   localparam logic [14:0] C_RST   = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 3'b010, 1'b0, 1'b0};
   localparam logic [14:0] C_DEC   = {7'b0, 1'b0, 2'b11, 3'b010, 2'b0};
   localparam logic [14:0] C_AIMM  = {7'b0, 1'b1, 2'b10, 3'b010, 2'b0};
   localparam logic [14:0] C_MRD   = {1'b0, 1'b1, 13'b0};
   localparam logic [14:0] C_MWB   = {4'b0, 1'b1, 1'b0, 1'b1, 8'b0};
   localparam logic [14:0] C_MWR   = {1'b0, 1'b1, 1'b1, 12'b0};
   localparam logic [14:0] C_AWB   = {4'b0, 1'b1, 1'b1, 1'b0, 8'b0};
   localparam logic [14:0] C_IWB   = {4'b0, 1'b1, 1'b0, 1'b0, 8'b0};
   localparam logic [14:0] C_BR_T  = {1'b1, 6'b0, 1'b1, 2'b00, 3'b110, 1'b1, 1'b0};
   localparam logic [14:0] C_BR_N  = {1'b0, 6'b0, 1'b1, 2'b00, 3'b110, 1'b1, 1'b0};
   localparam logic [14:0] C_ILL   = {14'b0, 1'b1};

   function automatic logic [14:0] exec_cw(input logic [2:0] op);
      return {7'b0, 1'b1, 2'b00, op, 2'b0};
   endfunction

   // One table entry: step k expectation is st[5-k] / cw[5-k]
   typedef struct packed {
      logic [5:0]       op;
      logic [5:0]       fn;
      logic             zero;
      logic [3:0]       len;
      logic [5:0][3:0]  st;
      logic [5:0][14:0] cw;
   } vec_t;

`ifdef BNE_EN
   localparam int NV = 12;
`else
   localparam int NV = 10;
`endif

   vec_t vecs [NV];

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Two reset cycles, released 1 ns after an edge: the DUT then sits in FETCH.
   task automatic do_reset();
      reset = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      #1;
   endtask

   initial begin
      vecs[0]  = '{6'h23, 6'h00, 1'b0, 4'd6, {S_FE, S_DE, S_MA, S_MR, S_MW, S_FE},
                   {C_FETCH, C_DEC, C_AIMM, C_MRD, C_MWB, C_FETCH}};
      vecs[1]  = '{6'h2B, 6'h00, 1'b0, 4'd5, {S_FE, S_DE, S_MA, S_SW, S_FE, 4'd0},
                   {C_FETCH, C_DEC, C_AIMM, C_MWR, C_FETCH, 15'd0}};
      vecs[2]  = '{6'h00, 6'h20, 1'b0, 4'd5, {S_FE, S_DE, S_EX, S_AW, S_FE, 4'd0},
                   {C_FETCH, C_DEC, exec_cw(3'b010), C_AWB, C_FETCH, 15'd0}};
      vecs[3]  = '{6'h00, 6'h22, 1'b0, 4'd5, {S_FE, S_DE, S_EX, S_AW, S_FE, 4'd0},
                   {C_FETCH, C_DEC, exec_cw(3'b110), C_AWB, C_FETCH, 15'd0}};
      vecs[4]  = '{6'h00, 6'h24, 1'b1, 4'd5, {S_FE, S_DE, S_EX, S_AW, S_FE, 4'd0},
                   {C_FETCH, C_DEC, exec_cw(3'b000), C_AWB, C_FETCH, 15'd0}};
      vecs[5]  = '{6'h00, 6'h25, 1'b0, 4'd5, {S_FE, S_DE, S_EX, S_AW, S_FE, 4'd0},
                   {C_FETCH, C_DEC, exec_cw(3'b001), C_AWB, C_FETCH, 15'd0}};
      vecs[6]  = '{6'h00, 6'h2A, 1'b0, 4'd5, {S_FE, S_DE, S_EX, S_AW, S_FE, 4'd0},
                   {C_FETCH, C_DEC, exec_cw(3'b111), C_AWB, C_FETCH, 15'd0}};
      vecs[7]  = '{6'h08, 6'h00, 1'b0, 4'd5, {S_FE, S_DE, S_IE, S_IW, S_FE, 4'd0},
                   {C_FETCH, C_DEC, C_AIMM, C_IWB, C_FETCH, 15'd0}};
      vecs[8]  = '{6'h04, 6'h00, 1'b1, 4'd4, {S_FE, S_DE, S_BR, S_FE, 4'd0, 4'd0},
                   {C_FETCH, C_DEC, C_BR_T, C_FETCH, 15'd0, 15'd0}};
      vecs[9]  = '{6'h04, 6'h00, 1'b0, 4'd4, {S_FE, S_DE, S_BR, S_FE, 4'd0, 4'd0},
                   {C_FETCH, C_DEC, C_BR_N, C_FETCH, 15'd0, 15'd0}};
`ifdef BNE_EN
      vecs[10] = '{6'h05, 6'h00, 1'b0, 4'd4, {S_FE, S_DE, S_BR, S_FE, 4'd0, 4'd0},
                   {C_FETCH, C_DEC, C_BR_T, C_FETCH, 15'd0, 15'd0}};
      vecs[11] = '{6'h05, 6'h00, 1'b1, 4'd4, {S_FE, S_DE, S_BR, S_FE, 4'd0, 4'd0},
                   {C_FETCH, C_DEC, C_BR_N, C_FETCH, 15'd0, 15'd0}};
`endif

      reset      = 1'b0;
      opcode_i   = 6'h00;
      funct_i    = 6'h00;
      alu_zero_i = 1'b0;

      // ---------------- reset state ----------------
      tick();
      tick();
      chk("reset state_o", 32'(state_o), 32'(S_FE));
      chk("reset ctl", 32'(ctl), 32'(C_RST));
      reset = 1'b1;
      #1;
      chk("release first cycle ctl", 32'(ctl), 32'(C_FETCH));

      // ---------------- table-driven instruction sequences ----------------
      for (int i = 0; i < NV; i++) begin
         opcode_i   = vecs[i].op;
         funct_i    = vecs[i].fn;
         alu_zero_i = vecs[i].zero;
         #1;
         for (int k = 0; k < int'(vecs[i].len); k++) begin
            if (k > 0) tick();
            chk($sformatf("vec%0d step%0d state", i, k), 32'(state_o), 32'(vecs[i].st[5-k]));
            chk($sformatf("vec%0d step%0d ctl", i, k), 32'(ctl), 32'(vecs[i].cw[5-k]));
         end
      end

      // ---------------- reset asserted in MEM_WRITE ----------------
      opcode_i = 6'h2B;
      funct_i  = 6'h00;
      tick();
      tick();
      tick();
      chk("sw reaches MEM_WRITE", 32'(state_o), 32'(S_SW));
      chk("sw MemSys before reset", 32'(enable_MemSys), 32'd1);
      reset = 1'b0;
      #1;
      for (int c = 0; c < 3; c++) begin
         if (c > 0) tick();
         chk($sformatf("midrst cyc%0d state_o", c), 32'(state_o), 32'(S_FE));
         chk($sformatf("midrst cyc%0d ctl", c), 32'(ctl), 32'(C_RST));
      end
      tick();
      reset = 1'b1;
      #1;
      chk("midrst release ctl", 32'(ctl), 32'(C_FETCH));
      tick();
      chk("midrst then DECODE", 32'(state_o), 32'(S_DE));

      // ---------------- illegal funct ----------------
      do_reset();
      opcode_i = 6'h00;
      funct_i  = 6'h3F;
      chk("badfn FETCH", 32'(state_o), 32'(S_FE));
      tick();
      chk("badfn DECODE", 32'(state_o), 32'(S_DE));
      tick();
      chk("badfn EXECUTE", 32'(state_o), 32'(S_EX));
      chk("badfn EXECUTE rf", 32'(enable_RF), 32'd0);
      for (int c = 0; c < 10; c++) begin
         tick();
         chk($sformatf("badfn ill%0d state", c), 32'(state_o), 32'(S_IL));
         chk($sformatf("badfn ill%0d ctl", c), 32'(ctl), 32'(C_ILL));
      end
      reset = 1'b0;
      #1;
      chk("badfn reset illegal_o", 32'(illegal_o), 32'd0);
      chk("badfn reset state_o", 32'(state_o), 32'(S_FE));
      tick();
      reset = 1'b1;
      #1;
      chk("badfn recovered ctl", 32'(ctl), 32'(C_FETCH));

      // ---------------- unsupported opcode (jump) ----------------
      do_reset();
      opcode_i = 6'h02;
      funct_i  = 6'h20;
      tick();
      tick();
      chk("badop ILLEGAL", 32'(state_o), 32'(S_IL));
      chk("badop illegal_o", 32'(illegal_o), 32'd1);

`ifndef BNE_EN
      // ---------------- bne without the feature traps ----------------
      do_reset();
      opcode_i   = 6'h05;
      funct_i    = 6'h00;
      alu_zero_i = 1'b0;
      tick();
      chk("bne DECODE", 32'(state_o), 32'(S_DE));
      for (int c = 0; c < 10; c++) begin
         tick();
         chk($sformatf("bne ill%0d state", c), 32'(state_o), 32'(S_IL));
         chk($sformatf("bne ill%0d ctl", c), 32'(ctl), 32'(C_ILL));
      end
`endif

      do_reset();
      chk("final FETCH", 32'(state_o), 32'(S_FE));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
